// File: rtl/alu_sequencer_if.sv
// Instruction handshake and ALU request/ack bus for alu_sequencer.
// master = sequencer side, slave = instruction source and ALU side.
interface alu_sequencer_if #(
    parameter int DW = 20
);
    logic          instr_valid;
    logic [19:0]   instr;
    logic          instr_ready;
    logic          alu_req;
    logic [4:0]    alu_op;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_cin;
    logic          alu_ack;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          alu_sign;
    logic          alu_carry;

    modport master (
        input  instr_valid, instr, alu_ack, alu_result,
        input  alu_zero, alu_sign, alu_carry,
        output instr_ready, alu_req, alu_op, alu_a, alu_b, alu_cin
    );

    modport slave (
        output instr_valid, instr, alu_ack, alu_result,
        output alu_zero, alu_sign, alu_carry,
        input  instr_ready, alu_req, alu_op, alu_a, alu_b, alu_cin
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer driving an external ALU.
// Flow ops retire in DECODE; ALU ops go through EXEC and WB.
module alu_sequencer #(
    parameter int DW          = 20,
    parameter int NREG        = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_sequencer_if.master      bus,
    output logic [DW-1:0]        pc,
    output logic [2:0]           sr,
    output logic                 retire,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    input  logic [2:0]           dbg_sel,
    output logic [DW-1:0]        dbg_data
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    localparam logic [4:0] OP_TRAP = 5'h01;
    localparam logic [4:0] OP_JMP  = 5'h02;
    localparam logic [4:0] OP_JZ   = 5'h03;
    localparam logic [4:0] OP_JS   = 5'h04;
    localparam logic [4:0] OP_JZS  = 5'h05;
    localparam logic [4:0] OP_LSR  = 5'h06;
    localparam logic [4:0] OP_XSR  = 5'h07;
    localparam logic [4:0] OP_NOT  = 5'h08;
    localparam logic [4:0] OP_SBC  = 5'h16;
    localparam logic [4:0] OP_LE   = 5'h1B;
    localparam logic [4:0] OP_LDI  = 5'h1C;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [19:0]   r_instr;
    logic [DW-1:0] r_pc;
    logic [2:0]    r_sr;
    logic [DW-1:0] r_regs [NREG];
    logic [DW-1:0] r_res;
    logic [2:0]    r_flags;
    logic [TW-1:0] r_tmo;
    logic [1:0]    r_cause;

    logic [4:0]    w_op;
    logic [2:0]    w_rd;
    logic [2:0]    w_rs;
    logic [8:0]    w_imm;
    logic [DW-1:0] w_rd_val;
    logic [DW-1:0] w_rs_val;
    logic [DW-1:0] w_pc_inc;
    logic          w_is_trap;
    logic          w_is_ill;
    logic          w_is_alu;

    logic [DW-1:0] w_pc_nxt;
    logic [2:0]    w_sr_nxt;
    logic          w_we;
    logic [DW-1:0] w_wd;
    logic          w_cap;
    logic [TW-1:0] w_tmo_nxt;
    logic [1:0]    w_cause_nxt;
    logic          w_ready;
    logic          w_req;
    logic          w_retire;

    assign w_op      = r_instr[19:15];
    assign w_rd      = r_instr[14:12];
    assign w_rs      = r_instr[11:9];
    assign w_imm     = r_instr[8:0];
    assign w_rd_val  = r_regs[w_rd];
    assign w_rs_val  = r_regs[w_rs];
    assign w_pc_inc  = r_pc + DW'(1);
    assign w_is_trap = (w_op == OP_TRAP);
    assign w_is_ill  = (w_op > OP_LDI);
    assign w_is_alu  = (w_op >= OP_NOT) && (w_op <= OP_LE);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_sr_nxt    = r_sr;
        w_we        = 1'b0;
        w_wd        = r_res;
        w_cap       = 1'b0;
        w_tmo_nxt   = r_tmo;
        w_cause_nxt = r_cause;
        w_ready     = 1'b0;
        w_req       = 1'b0;
        w_retire    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                w_tmo_nxt = '0;
                unique case (1'b1)
                    w_is_trap: begin
                        w_state_nxt = HALT;
                        w_cause_nxt = 2'b01;
                    end
                    w_is_ill: begin
                        w_state_nxt = HALT;
                        w_cause_nxt = 2'b10;
                    end
                    w_is_alu: begin
                        w_state_nxt = EXEC;
                    end
                    default: begin
                        w_state_nxt = IDLE;
                        w_retire    = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        case (w_op)
                            OP_JMP: w_pc_nxt = w_rs_val;
                            OP_JZ:  if (r_sr[1]) w_pc_nxt = w_rs_val;
                            OP_JS:  if (r_sr[2]) w_pc_nxt = w_rs_val;
                            OP_JZS: if (|r_sr[2:1]) w_pc_nxt = w_rs_val;
                            OP_LSR: w_sr_nxt = w_imm[2:0];
                            OP_XSR: w_sr_nxt = r_sr ^ w_imm[2:0];
                            OP_LDI: begin
                                w_we = 1'b1;
                                w_wd = {{(DW-9){1'b0}}, w_imm};
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
            EXEC: begin
                w_req = 1'b1;
                if (bus.alu_ack) begin
                    w_cap       = 1'b1;
                    w_state_nxt = WB;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = HALT;
                    w_cause_nxt = 2'b11;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            WB: begin
                // compares (EQ..LE) only update flags
                w_we        = (w_op <= OP_SBC);
                w_wd        = r_res;
                w_sr_nxt    = r_flags;
                w_pc_nxt    = w_pc_inc;
                w_retire    = 1'b1;
                w_state_nxt = IDLE;
            end
            HALT: ;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_instr <= '0;
            r_pc    <= '0;
            r_sr    <= '0;
            r_res   <= '0;
            r_flags <= '0;
            r_tmo   <= '0;
            r_cause <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_sr    <= w_sr_nxt;
            r_tmo   <= w_tmo_nxt;
            r_cause <= w_cause_nxt;
            if (w_ready && bus.instr_valid) begin
                r_instr <= bus.instr;
            end
            if (w_we) begin
                r_regs[w_rd] <= w_wd;
            end
            if (w_cap) begin
                r_res   <= bus.alu_result;
                r_flags <= {bus.alu_sign, bus.alu_zero, bus.alu_carry};
            end
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.alu_req     = w_req;
    assign bus.alu_op      = w_op;
    assign bus.alu_a       = w_rd_val;
    assign bus.alu_b       = w_rs_val;
    assign bus.alu_cin     = r_sr[0];

    assign pc         = r_pc;
    assign sr         = r_sr;
    assign retire     = w_retire;
    assign trap       = (r_state == HALT);
    assign trap_cause = r_cause;
    assign dbg_data   = r_regs[dbg_sel];

endmodule
